// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//   Multi-cycle control sequencer for a small MIPS-like CPU. It walks each
//   instruction through FETCH / DECODE / EXEC / MEM / WB. It handshakes with
//   the instruction and data memories and bounds each handshake with a wait
//   counter. It drives the datapath strobes combinationally from the
//   registered state and the latched opcode/funct.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 leave IDLE and begin fetching
//   opcode, funct         instruction fields [31:26] / [5:0], sampled on fetch ack
//   alu_zero              ALU zero flag, used by beq in EXEC
//   imem_req / imem_ack   instruction-memory handshake
//   dmem_req / dmem_we /
//   dmem_ack              data-memory handshake
//   ir_we, pc_we, pc_sel,
//   reg_we, alu_op        datapath strobes
//   state, halted, error,
//   instr_count           status (instr_count saturates at 16'hFFFF)
// ---------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        alu_zero,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        reg_we,
    output logic [2:0]  alu_op,
    output logic [2:0]  state,
    output logic        halted,
    output logic        error,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // At least two bits so the counter arithmetic below stays well formed
    // for very small WAIT_MAX values.
    localparam int              WCW        = (WAIT_MAX < 2) ? 2 : $clog2(WAIT_MAX + 1);
    localparam logic [WCW-1:0]  WAIT_LIMIT = WCW'(WAIT_MAX);
    localparam logic [WCW-1:0]  WAIT_ONE   = WCW'(1);
    localparam logic [WCW-1:0]  WAIT_ZERO  = WCW'(0);

    state_t          state_r;
    logic [5:0]      opcode_r;
    logic [5:0]      funct_r;
    logic [WCW-1:0]  wait_cnt_r;
    logic [15:0]     instr_count_r;
    logic            instr_legal_s;

    // True for the R-type function codes this sequencer knows how to run.
    function automatic logic funct_supported(input logic [5:0] fn);
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_supported = 1'b1;
            default:                                funct_supported = 1'b0;
        endcase
    endfunction

    // True when an opcode/funct pair is an instruction DECODE accepts.
    function automatic logic instr_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE:                      instr_legal = funct_supported(fn);
            OP_J, OP_BEQ, OP_LW, OP_SW,
            OP_HALT:                       instr_legal = 1'b1;
            default:                       instr_legal = 1'b0;
        endcase
    endfunction

    // ALU operation for an instruction; non-ALU instructions map to 000.
    function automatic logic [2:0] alu_decode(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD:  alu_decode = 3'b010;
                    FN_SUB:  alu_decode = 3'b110;
                    FN_AND:  alu_decode = 3'b000;
                    FN_OR:   alu_decode = 3'b001;
                    FN_SLT:  alu_decode = 3'b111;
                    default: alu_decode = 3'b000;
                endcase
            end
            OP_LW, OP_SW: alu_decode = 3'b010;
            OP_BEQ:       alu_decode = 3'b110;
            default:      alu_decode = 3'b000;
        endcase
    endfunction

    assign instr_legal_s = instr_legal(opcode_r, funct_r);

    // State register, latched instruction fields, handshake wait counter and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            opcode_r      <= 6'd0;
            funct_r       <= 6'd0;
            wait_cnt_r    <= WAIT_ZERO;
            instr_count_r <= 16'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    wait_cnt_r <= WAIT_ZERO;
                    if (start) begin
                        state_r <= S_FETCH;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    // An acknowledge on the final allowed cycle beats the timeout.
                    if (imem_ack) begin
                        opcode_r   <= opcode;
                        funct_r    <= funct;
                        wait_cnt_r <= WAIT_ZERO;
                        state_r    <= S_DECODE;
                    end else if (wait_cnt_r == WAIT_LIMIT) begin
                        wait_cnt_r <= WAIT_ZERO;
                        state_r    <= S_ERR;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                        state_r    <= S_FETCH;
                    end
                end
                S_DECODE: begin
                    wait_cnt_r <= WAIT_ZERO;
                    if (instr_legal_s && (instr_count_r != 16'hFFFF)) begin
                        instr_count_r <= instr_count_r + 16'd1;
                    end else begin
                        instr_count_r <= instr_count_r;
                    end
                    if (!instr_legal_s) begin
                        state_r <= S_ERR;
                    end else begin
                        case (opcode_r)
                            OP_HALT:                    state_r <= S_HALT;
                            OP_J:                       state_r <= S_FETCH;
                            OP_RTYPE, OP_LW, OP_SW,
                            OP_BEQ:                     state_r <= S_EXEC;
                            default:                    state_r <= S_ERR;
                        endcase
                    end
                end
                S_EXEC: begin
                    wait_cnt_r <= WAIT_ZERO;
                    case (opcode_r)
                        OP_RTYPE:     state_r <= S_WB;
                        OP_LW, OP_SW: state_r <= S_MEM;
                        OP_BEQ:       state_r <= S_FETCH;
                        default:      state_r <= S_ERR;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        wait_cnt_r <= WAIT_ZERO;
                        if (opcode_r == OP_SW) begin
                            state_r <= S_FETCH;
                        end else begin
                            state_r <= S_WB;
                        end
                    end else if (wait_cnt_r == WAIT_LIMIT) begin
                        wait_cnt_r <= WAIT_ZERO;
                        state_r    <= S_ERR;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                        state_r    <= S_MEM;
                    end
                end
                S_WB: begin
                    wait_cnt_r <= WAIT_ZERO;
                    state_r    <= S_FETCH;
                end
                S_HALT: begin
                    wait_cnt_r <= WAIT_ZERO;
                    state_r    <= S_HALT;
                end
                S_ERR: begin
                    wait_cnt_r <= WAIT_ZERO;
                    state_r    <= S_ERR;
                end
                default: begin
                    wait_cnt_r <= WAIT_ZERO;
                    state_r    <= S_ERR;
                end
            endcase
        end
    end

    // Datapath strobes decoded from the current state, latched instruction and handshake inputs.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 2'b00;
        reg_we   = 1'b0;
        alu_op   = 3'b000;
        case (state_r)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    pc_sel = 2'b00;
                end else begin
                    ir_we  = 1'b0;
                end
            end
            S_DECODE: begin
                if (opcode_r == OP_J) begin
                    pc_we  = 1'b1;
                    pc_sel = 2'b10;
                end else begin
                    pc_we  = 1'b0;
                end
            end
            S_EXEC: begin
                alu_op = alu_decode(opcode_r, funct_r);
                if (opcode_r == OP_BEQ) begin
                    pc_we  = alu_zero;
                    pc_sel = 2'b01;
                end else begin
                    pc_we  = 1'b0;
                end
            end
            S_MEM: begin
                alu_op   = alu_decode(opcode_r, funct_r);
                dmem_req = 1'b1;
                dmem_we  = (opcode_r == OP_SW);
            end
            S_WB: begin
                alu_op = alu_decode(opcode_r, funct_r);
                reg_we = 1'b1;
            end
            default: begin
                alu_op = 3'b000;
            end
        endcase
    end

    assign state       = state_r;
    assign halted      = (state_r == S_HALT);
    assign error       = (state_r == S_ERR);
    assign instr_count = instr_count_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        alu_zero;
    logic        imem_req;
    logic        imem_ack;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        reg_we;
    logic [2:0]  alu_op;
    logic [2:0]  state;
    logic        halted;
    logic        error;
    logic [15:0] instr_count;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_HALT = 6'b111111;

    cpu_sequencer #(.WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we),
        .alu_op(alu_op), .state(state), .halted(halted), .error(error),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        start = 1'b1;
        adv();
        start = 1'b0;
    endtask

    // From FETCH: acknowledge immediately with op/fn, land in DECODE with the
    // input bus scrambled so decoding must use the latched copy.
    task automatic fetch_instr(input logic [5:0] op, input logic [5:0] fn);
        imem_ack = 1'b1; opcode = op; funct = fn;
        adv();
        imem_ack = 1'b0; opcode = 6'b010101; funct = 6'b000000;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        adv();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; opcode = 6'd0; funct = 6'd0; alu_zero = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        #12;
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if ({imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we, alu_op, halted, error} !== 13'd0) begin n_err++; $display("FAIL reset_outputs: got nonzero strobes"); end
        n_cmp++; if (instr_count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", instr_count); end
        adv();
        rst_n = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
        adv();
        #1;
        n_cmp++; if (state !== 3'd0 || imem_req !== 1'b0) begin n_err++; $display("FAIL idle_ack_ignored: got state %0d want 0", state); end
        imem_ack = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic test_rtype();
        start = 1'b1; #1;
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL rt_idle: got %0d want 0", state); end
        adv(); start = 1'b0; #1;
        n_cmp++; if (state !== 3'd1 || imem_req !== 1'b1 || ir_we !== 1'b0) begin n_err++; $display("FAIL rt_fetch1: got state %0d req %0b want 1/1", state, imem_req); end
        adv(); #1;
        n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL rt_fetch2: got %0d want 1", state); end
        adv(); imem_ack = 1'b1; opcode = OP_R; funct = 6'b100000; #1;
        n_cmp++; if (state !== 3'd1 || ir_we !== 1'b1 || pc_we !== 1'b1 || pc_sel !== 2'b00) begin n_err++; $display("FAIL rt_fetch_ack: got st %0d ir %0b pc %0b sel %0b want 1/1/1/00", state, ir_we, pc_we, pc_sel); end
        adv(); imem_ack = 1'b0; opcode = 6'b111111; funct = 6'd0; #1;
        n_cmp++; if (state !== 3'd2 || ir_we !== 1'b0 || pc_we !== 1'b0) begin n_err++; $display("FAIL rt_decode: got %0d want 2", state); end
        adv(); #1;
        n_cmp++; if (state !== 3'd3 || alu_op !== 3'b010 || reg_we !== 1'b0) begin n_err++; $display("FAIL rt_exec: got st %0d alu %0b want 3/010", state, alu_op); end
        adv(); #1;
        n_cmp++; if (state !== 3'd5 || reg_we !== 1'b1 || alu_op !== 3'b010) begin n_err++; $display("FAIL rt_wb: got st %0d we %0b alu %0b want 5/1/010", state, reg_we, alu_op); end
        adv(); #1;
        n_cmp++; if (state !== 3'd1 || reg_we !== 1'b0 || instr_count !== 16'd1) begin n_err++; $display("FAIL rt_done: got st %0d we %0b cnt %0d want 1/0/1", state, reg_we, instr_count); end
    endtask

    task automatic test_lw();
        fetch_instr(OP_LW, 6'd0); #1;
        n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL lw_decode: got %0d want 2", state); end
        adv(); #1;
        n_cmp++; if (state !== 3'd3 || alu_op !== 3'b010) begin n_err++; $display("FAIL lw_exec: got st %0d alu %0b want 3/010", state, alu_op); end
        for (int i = 1; i <= 4; i++) begin
            adv();
            if (i == 4) dmem_ack = 1'b1;
            #1;
            n_cmp++; if (state !== 3'd4 || dmem_req !== 1'b1 || dmem_we !== 1'b0 || alu_op !== 3'b010) begin n_err++; $display("FAIL lw_mem%0d: got st %0d req %0b we %0b want 4/1/0", i, state, dmem_req, dmem_we); end
        end
        adv(); dmem_ack = 1'b0; #1;
        n_cmp++; if (state !== 3'd5 || reg_we !== 1'b1) begin n_err++; $display("FAIL lw_wb: got st %0d we %0b want 5/1", state, reg_we); end
        adv(); #1;
        n_cmp++; if (state !== 3'd1 || instr_count !== 16'd2) begin n_err++; $display("FAIL lw_done: got st %0d cnt %0d want 1/2", state, instr_count); end
    endtask

    task automatic test_sw();
        fetch_instr(OP_SW, 6'd0);
        adv(); adv(); dmem_ack = 1'b1; #1;
        n_cmp++; if (state !== 3'd4 || dmem_req !== 1'b1 || dmem_we !== 1'b1) begin n_err++; $display("FAIL sw_mem: got st %0d req %0b we %0b want 4/1/1", state, dmem_req, dmem_we); end
        adv(); dmem_ack = 1'b0; #1;
        n_cmp++; if (state !== 3'd1 || reg_we !== 1'b0 || instr_count !== 16'd3) begin n_err++; $display("FAIL sw_done: got st %0d cnt %0d want 1/3", state, instr_count); end
    endtask

    task automatic test_beq(input logic zero, input logic [15:0] exp_cnt);
        fetch_instr(OP_BEQ, 6'd0);
        adv(); alu_zero = zero; #1;
        n_cmp++; if (state !== 3'd3 || pc_we !== zero || pc_sel !== 2'b01 || alu_op !== 3'b110) begin n_err++; $display("FAIL beq_exec_z%0b: got st %0d pc_we %0b sel %0b alu %0b want 3/%0b/01/110", zero, state, pc_we, pc_sel, alu_op, zero); end
        adv(); alu_zero = 1'b0; #1;
        n_cmp++; if (state !== 3'd1 || instr_count !== exp_cnt) begin n_err++; $display("FAIL beq_done_z%0b: got st %0d cnt %0d want 1/%0d", zero, state, instr_count, exp_cnt); end
    endtask

    task automatic test_jump();
        fetch_instr(OP_J, 6'd0); #1;
        n_cmp++; if (state !== 3'd2 || pc_we !== 1'b1 || pc_sel !== 2'b10) begin n_err++; $display("FAIL j_decode: got st %0d pc_we %0b sel %0b want 2/1/10", state, pc_we, pc_sel); end
        adv(); #1;
        n_cmp++; if (state !== 3'd1 || instr_count !== 16'd6) begin n_err++; $display("FAIL j_done: got st %0d cnt %0d want 1/6", state, instr_count); end
    endtask

    task automatic test_ack_at_limit();
        repeat (15) adv();
        imem_ack = 1'b1; opcode = OP_R; funct = 6'b100010; #1;
        n_cmp++; if (state !== 3'd1 || ir_we !== 1'b1) begin n_err++; $display("FAIL lim_fetch16: got st %0d ir %0b want 1/1", state, ir_we); end
        adv(); imem_ack = 1'b0; #1;
        n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL lim_decode: got %0d want 2", state); end
        adv(); #1;
        n_cmp++; if (state !== 3'd3 || alu_op !== 3'b110) begin n_err++; $display("FAIL lim_sub_exec: got st %0d alu %0b want 3/110", state, alu_op); end
        adv(); adv(); #1;
        n_cmp++; if (state !== 3'd1 || instr_count !== 16'd7) begin n_err++; $display("FAIL lim_done: got st %0d cnt %0d want 1/7", state, instr_count); end
    endtask

    task automatic test_halt();
        fetch_instr(OP_HALT, 6'd0);
        adv(); #1;
        n_cmp++; if (state !== 3'd6 || halted !== 1'b1 || error !== 1'b0 || instr_count !== 16'd8) begin n_err++; $display("FAIL halt_enter: got st %0d halted %0b cnt %0d want 6/1/8", state, halted, instr_count); end
        start = 1'b1; imem_ack = 1'b1;
        repeat (3) adv();
        #1;
        n_cmp++; if (state !== 3'd6 || imem_req !== 1'b0 || pc_we !== 1'b0 || ir_we !== 1'b0) begin n_err++; $display("FAIL halt_absorb: got st %0d req %0b want 6/0", state, imem_req); end
        start = 1'b0; imem_ack = 1'b0;
        rst_n = 1'b0; #1;
        n_cmp++; if (state !== 3'd0 || halted !== 1'b0 || instr_count !== 16'd0) begin n_err++; $display("FAIL halt_reset: got st %0d cnt %0d want 0/0", state, instr_count); end
        adv(); rst_n = 1'b1;
    endtask

    task automatic test_illegal();
        start_run();
        fetch_instr(6'b001111, 6'd0);
        adv(); #1;
        n_cmp++; if (state !== 3'd7 || error !== 1'b1 || instr_count !== 16'd0) begin n_err++; $display("FAIL ill_opcode: got st %0d err %0b cnt %0d want 7/1/0", state, error, instr_count); end
        pulse_reset();
        start_run();
        fetch_instr(OP_R, 6'b000001);
        adv(); #1;
        n_cmp++; if (state !== 3'd7 || instr_count !== 16'd0) begin n_err++; $display("FAIL ill_funct: got st %0d cnt %0d want 7/0", state, instr_count); end
        pulse_reset();
    endtask

    task automatic test_timeout();
        start_run();
        repeat (15) adv();
        #1;
        n_cmp++; if (state !== 3'd1 || imem_req !== 1'b1) begin n_err++; $display("FAIL to_fetch16: got st %0d req %0b want 1/1", state, imem_req); end
        adv(); #1;
        n_cmp++; if (state !== 3'd7 || error !== 1'b1 || imem_req !== 1'b0) begin n_err++; $display("FAIL to_err: got st %0d err %0b want 7/1", state, error); end
        start = 1'b1; imem_ack = 1'b1;
        repeat (4) adv();
        #1;
        n_cmp++; if (state !== 3'd7 || error !== 1'b1 || imem_req !== 1'b0 || ir_we !== 1'b0) begin n_err++; $display("FAIL to_sticky: got st %0d err %0b want 7/1", state, error); end
        start = 1'b0; imem_ack = 1'b0;
        pulse_reset();
    endtask

    task automatic test_reset_mem();
        start_run();
        fetch_instr(OP_LW, 6'd0);
        adv(); adv(); #1;
        n_cmp++; if (state !== 3'd4 || dmem_req !== 1'b1 || instr_count !== 16'd1) begin n_err++; $display("FAIL rm_in_mem: got st %0d req %0b want 4/1", state, dmem_req); end
        rst_n = 1'b0; #1;
        n_cmp++; if (state !== 3'd0 || dmem_req !== 1'b0 || alu_op !== 3'b000 || instr_count !== 16'd0) begin n_err++; $display("FAIL rm_async: got st %0d req %0b alu %0b cnt %0d want all 0", state, dmem_req, alu_op, instr_count); end
        adv();
        rst_n = 1'b1; start = 1'b1;
        adv(); start = 1'b0; #1;
        n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL rm_first_edge: got %0d want 1", state); end
        pulse_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rtype();
        test_lw();
        test_sw();
        test_beq(1'b1, 16'd4);
        test_beq(1'b0, 16'd5);
        test_jump();
        test_ack_at_limit();
        test_halt();
        test_illegal();
        test_timeout();
        test_reset_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: the maximum number of wait cycles allowed for a memory acknowledge.
REQ-002 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
REQ-003 SHALL have port start  in  1: begins execution from IDLE.
REQ-004 SHALL have ports:
- opcode  in  6  instruction [31:26].
- funct  in  6  instruction [5:0].
- alu_zero  in  1  ALU zero flag.
REQ-005 SHALL have instruction-memory handshake ports:
- imem_req  out  1
- imem_ack  in  1
REQ-006 SHALL have data-memory ports:
- dmem_req  out  1
- dmem_we  out  1
- dmem_ack  in  1
REQ-007 SHALL have datapath strobe ports:
- ir_we  out  1
- pc_we  out  1
- pc_sel  out  2  00=PC+1, 01=branch target, 10=jump target.
- reg_we  out  1
- alu_op  out  3
REQ-008 SHALL have status ports:
- state  out  3
- halted  out  1
- error  out  1
- instr_count  out  16

Function
REQ-009 SHALL use these state encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
REQ-010 SHALL register the state; all control outputs SHALL be combinational from the state, the registered opcode/funct and the inputs, and SHALL be 0 unless stated otherwise.
REQ-011 SHALL latch opcode and funct on the FETCH acknowledge edge, and SHALL decode from the latched copies.
REQ-012 IDLE: start=1 SHALL move to FETCH; otherwise stay in IDLE.
REQ-013 FETCH: imem_req=1 every cycle; on imem_ack=1, ir_we=1, pc_we=1 and pc_sel=00 for that cycle, then next state DECODE.
REQ-014 DECODE: next state SHALL be selected as follows:
- halt (111111) -> HALT.
- j (000010) -> pc_we=1, pc_sel=10, then FETCH.
- R-type (000000), lw (100011), sw (101011), beq (000100) -> EXEC.
- any other opcode -> ERR.
REQ-015 DECODE of an R-type with an unsupported funct SHALL go to ERR.
REQ-016 alu_op for R-type funct SHALL be: 100000 add->010, 100010 sub->110, 100100 and->000, 100101 or->001, 101010 slt->111.
REQ-017 alu_op SHALL be 010 for lw/sw and 110 for beq; alu_op SHALL be valid in EXEC and held through MEM/WB.
REQ-018 EXEC: next state SHALL be selected as follows:
- R-type -> WB.
- lw/sw -> MEM.
- beq -> pc_we=alu_zero, pc_sel=01, then FETCH.
REQ-019 MEM: dmem_req=1 every cycle, and dmem_we=1 for sw; on dmem_ack=1, sw -> FETCH and lw -> WB.
REQ-020 WB: reg_we=1 for exactly one cycle, then FETCH.
REQ-021 A wait counter SHALL clear on entry to FETCH or MEM and increment each non-acknowledged cycle in that state.
REQ-022 If the wait counter equals WAIT_MAX with no acknowledge, next state SHALL be ERR.
REQ-023 An acknowledge in the same cycle that the wait counter equals WAIT_MAX SHALL win over the timeout.
REQ-024 An acknowledge outside FETCH/MEM SHALL be ignored.
REQ-025 instr_count SHALL increment by 1 on each DECODE of a legal instruction, including halt, and SHALL saturate at 16'hFFFF.
REQ-026 HALT and ERR SHALL be absorbing: no strobes asserted, start ignored, exit only by reset.
REQ-027 halted SHALL equal (state==HALT) and error SHALL equal (state==ERR).
REQ-028 start SHALL be ignored outside IDLE.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, wait counter=0, instr_count=0, latched opcode/funct=0, and all outputs 0.
REQ-030 Reset asserted mid-handshake SHALL drop imem_req/dmem_req in the same cycle.
REQ-031 The first rising clk edge after rst_n releases SHALL evaluate IDLE.

Verification
REQ-032 R-type: start, imem_ack after 2 waits, add (op 000000, funct 100000) -> states 1,1,1,2,3,5,1; reg_we one cycle; alu_op=010; instr_count=1.
REQ-033 Memory ops:
- lw with dmem_ack after 3 cycles -> MEM for 4 cycles, then WB with reg_we=1.
- sw -> dmem_we=1 while in MEM, no WB, then FETCH.
REQ-034 beq:
- alu_zero=1 -> pc_we=1, pc_sel=01 in EXEC.
- alu_zero=0 -> pc_we=0; both return to FETCH.
REQ-035 Timeout with WAIT_MAX=15:
- imem_ack never asserted -> ERR after 16 FETCH cycles; error=1 sticky, start ignored.
- ack on cycle 16 -> DECODE.
REQ-036 Illegal opcode 001111 -> ERR from DECODE.
REQ-037 halt -> HALT, halted=1, instr_count incremented.
REQ-038 rst_n pulsed low during MEM -> outputs 0 with no clk edge, state=0.
